spi_flash_sequencer: RTL

Command sequencer in front of the SPI flash byte engine (read/write/erase strobe interface). It accepts one erase-32K or page-program command at a time and drives the engine's level strobes in the correct order. After each erase or program it polls the flash status register until WIP clears, then reports completion or timeout. It sits between the configuration/update logic (command and payload stream) and the flash engine.

---
 rtl/spi_flash_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: runs one erase-32K or page-program command at a time
// against the SPI flash byte engine. It orders the engine strobes, inserts
// idle gaps between phases and polls the status register until WIP clears
// or the poll budget runs out.
module spi_flash_sequencer #(
    parameter int unsigned POLL_LIMIT   = 1048576,
    parameter int unsigned GUARD_CYCLES = 32,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len_m1,

    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,

    output logic        busy,
    output logic        done,
    output logic        error,

    output logic        fl_read_strobe,
    output logic        fl_write_strobe,
    output logic        fl_erase_strobe,
    output logic [23:0] fl_start_addr,

    input  logic [7:0]  fl_m_tdata,
    input  logic        fl_m_tvalid,
    output logic        fl_m_tready,

    output logic [7:0]  fl_s_tdata,
    output logic        fl_s_tvalid,
    input  logic        fl_s_tready,

    input  logic        fl_finished
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ERASE,
        S_PROG,
        S_GUARD,
        S_GAP,
        S_POLL,
        S_DONE
    } state_t;

    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [20:0] POLL_MAX   = 21'(POLL_LIMIT);

    state_t      state, state_d;
    state_t      next_phase, next_phase_d;

    logic        op_q;
    logic [23:0] addr_q;
    logic [7:0]  len_m1_q;
    logic        accept;

    logic [8:0]  remaining, remaining_d;
    logic [20:0] poll_cnt, poll_cnt_d;
    logic [20:0] poll_inc;
    logic [15:0] cyc_cnt, cyc_cnt_d;
    logic        err_q, err_d;

    logic [8:0]  page_sum;
    logic        page_cross;
    logic        rem_nz;
    logic        byte_hs;
    logic        status_unused;

    // Only WIP (bit 0) of the status byte matters here.
    assign status_unused = ^fl_m_tdata[7:1];

    assign fl_start_addr = addr_q;
    assign fl_s_tdata    = s_tdata;

    assign page_sum   = {1'b0, addr_q[7:0]} + {1'b0, len_m1_q};
    assign page_cross = page_sum[8];
    assign rem_nz     = (remaining != 9'd0);
    assign byte_hs    = s_tvalid && rem_nz && fl_s_tready;
    assign poll_inc   = (&poll_cnt) ? poll_cnt : poll_cnt + 21'd1;

    // State, datapath and registered engine strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            next_phase      <= S_IDLE;
            op_q            <= 1'b0;
            addr_q          <= '0;
            len_m1_q        <= '0;
            remaining       <= '0;
            poll_cnt        <= '0;
            cyc_cnt         <= '0;
            err_q           <= 1'b0;
            fl_read_strobe  <= 1'b0;
            fl_write_strobe <= 1'b0;
            fl_erase_strobe <= 1'b0;
        end else begin
            state      <= state_d;
            next_phase <= next_phase_d;
            remaining  <= remaining_d;
            poll_cnt   <= poll_cnt_d;
            cyc_cnt    <= cyc_cnt_d;
            err_q      <= err_d;
            if (accept) begin
                op_q     <= cmd_op;
                addr_q   <= cmd_addr;
                len_m1_q <= cmd_len_m1;
            end
            // Strobes follow the upcoming state so they change on the same
            // edge as the state and never glitch toward the engine.
            fl_erase_strobe <= (state_d == S_ERASE);
            fl_write_strobe <= (state_d == S_PROG) || (state_d == S_GUARD);
            fl_read_strobe  <= (state_d == S_POLL);
        end
    end

    // Next-state logic and the handshake/status outputs.
    always_comb begin
        state_d      = state;
        next_phase_d = next_phase;
        remaining_d  = remaining;
        poll_cnt_d   = poll_cnt;
        cyc_cnt_d    = cyc_cnt;
        err_d        = err_q;
        accept       = 1'b0;
        cmd_ready    = 1'b0;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        error        = 1'b0;
        s_tready     = 1'b0;
        fl_s_tvalid  = 1'b0;
        fl_m_tready  = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept      = 1'b1;
                    remaining_d = {1'b0, cmd_len_m1} + 9'd1;
                    err_d       = 1'b0;
                    state_d     = S_CHECK;
                end
            end

            S_CHECK: begin
                if (op_q && page_cross) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (op_q) begin
                    state_d = S_PROG;
                end else begin
                    state_d = S_ERASE;
                end
            end

            S_ERASE: begin
                if (fl_finished) begin
                    state_d      = S_GAP;
                    next_phase_d = S_POLL;
                    cyc_cnt_d    = '0;
                end
            end

            S_PROG: begin
                fl_s_tvalid = s_tvalid && rem_nz;
                s_tready    = fl_s_tready && rem_nz;
                if (byte_hs) begin
                    remaining_d = remaining - 9'd1;
                end
                if ((byte_hs && remaining == 9'd1) || !rem_nz) begin
                    state_d   = S_GUARD;
                    cyc_cnt_d = '0;
                end
            end

            S_GUARD: begin
                if (cyc_cnt == GUARD_LAST) begin
                    state_d      = S_GAP;
                    next_phase_d = S_POLL;
                    cyc_cnt_d    = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt + 16'd1;
                end
            end

            S_GAP: begin
                if (cyc_cnt == GAP_LAST) begin
                    state_d = next_phase;
                    if (next_phase == S_POLL) begin
                        poll_cnt_d = '0;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt + 16'd1;
                end
            end

            S_POLL: begin
                fl_m_tready = 1'b1;
                if (fl_m_tvalid) begin
                    // A clear WIP wins even if this byte would exhaust the budget.
                    if (!fl_m_tdata[0]) begin
                        err_d        = 1'b0;
                        state_d      = S_GAP;
                        next_phase_d = S_DONE;
                        cyc_cnt_d    = '0;
                    end else begin
                        poll_cnt_d = poll_inc;
                        if (poll_inc >= POLL_MAX) begin
                            err_d        = 1'b1;
                            state_d      = S_GAP;
                            next_phase_d = S_DONE;
                            cyc_cnt_d    = '0;
                        end
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                error   = err_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
